// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame/baud settings
// used by both the RX core and the future TX core.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rxState_t;

    // Last counter value before the mid-start-bit sample.
    function automatic int halfBitLast(input int clksPerBit);
        return clksPerBit / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Received-byte stream between the UART receiver (master) and its consumer (slave).
interface uart_rx_core_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W
);

    logic [DATA_WIDTH-1:0] recvData;
    logic                  recvData_valid;
    logic                  recvData_ready;

    modport master (
        output recvData,
        output recvData_valid,
        input  recvData_ready
    );

    modport slave (
        input  recvData,
        input  recvData_valid,
        output recvData_ready
    );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is
// chosen per use so an idle line never looks like an edge after reset.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1-style UART receiver: mid-bit sampling of a synchronized rxd line, one-entry
// holding register on a valid/ready stream, framing and overrun pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = UART_DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rxd,
    uart_rx_core_if.master   rx,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(halfBitLast(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    rxState_t              state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic                  rxs;
    logic                  rxsPrev;
    logic                  fallEdge;
    logic                  stopTick;
    logic                  goodStop;
    logic                  accept;

    uart_sync #(.RESET_VAL(1'b1)) rxdSync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxs)
    );

    assign fallEdge = rxsPrev & ~rxs;
    assign stopTick = (state == STOP) && (cnt == BIT_LAST);
    assign goodStop = stopTick & rxs;
    assign accept   = rx.recvData_valid & rx.recvData_ready;

    // Bit-timing FSM; every state entry restarts the baud counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shiftReg <= '0;
            rxsPrev  <= 1'b1;
        end else begin
            rxsPrev <= rxs;
            case (state)
                IDLE: begin
                    if (fallEdge) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt      <= '0;
                        // Shifting in at the MSB leaves the first bit at the LSB once full.
                        shiftReg <= {rxs, shiftReg[DATA_WIDTH-1:1]};
                        idx      <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= rxs ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Holding register: a delivery wins over a plain accept, and an accept in the
    // delivery cycle frees the slot for the new byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx.recvData       <= '0;
            rx.recvData_valid <= 1'b0;
            frame_err         <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            frame_err <= stopTick & ~rxs;
            overrun   <= goodStop & rx.recvData_valid & ~rx.recvData_ready;
            if (goodStop) begin
                if (!rx.recvData_valid || rx.recvData_ready) begin
                    rx.recvData       <= shiftReg;
                    rx.recvData_valid <= 1'b1;
                end
            end else if (accept) begin
                rx.recvData_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames are driven bit by bit, one clk per step,
// with outputs observed 1 time unit after each rising edge.
module tb_uart_rx_core;

    localparam int CPB = 16;

    logic clk;
    logic reset;
    logic rxd;
    logic frame_err;
    logic overrun;

    int total;
    int bad;
    int cyc;
    int firstValid;
    int validCycles;
    int ferrCnt;
    int ovrCnt;
    int bothCnt;
    logic [7:0] dataFirst;

    uart_rx_core_if #(.DATA_WIDTH(8)) ifc ();

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx        (ifc),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearStats();
        cyc         = 0;
        firstValid  = -1;
        validCycles = 0;
        ferrCnt     = 0;
        ovrCnt      = 0;
        bothCnt     = 0;
        dataFirst   = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ifc.recvData_valid === 1'b1) begin
            validCycles++;
            if (firstValid < 0) begin
                firstValid = cyc;
                dataFirst  = ifc.recvData;
            end
        end
        if (frame_err === 1'b1) ferrCnt++;
        if (overrun === 1'b1) ovrCnt++;
        if (frame_err === 1'b1 && overrun === 1'b1) bothCnt++;
    endtask

    // readyPulseAt >= 0 drives ready high only in that step; resetAt >= 0 pulses reset.
    task automatic sendFrame(input logic [7:0] d, input logic stopLvl, input int stopLen,
                             input int readyPulseAt, input int resetAt);
        int nSteps;
        int b;
        clearStats();
        nSteps = 9 * CPB + stopLen;
        for (int n = 1; n <= nSteps; n++) begin
            b = (n - 1) / CPB;
            if (b == 0)      rxd = 1'b0;
            else if (b <= 8) rxd = d[b-1];
            else             rxd = stopLvl;
            if (readyPulseAt >= 0) ifc.recvData_ready = (n == readyPulseAt);
            reset = (n == resetAt);
            tick();
        end
        rxd   = 1'b1;
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clearStats();
        reset = 1'b1;
        rxd   = 1'b1;
        ifc.recvData_ready = 1'b0;
        repeat (3) tick();
        check("rst_data",  32'(ifc.recvData), 32'h00);
        check("rst_valid", 32'(ifc.recvData_valid), 32'h0);
        check("rst_ferr",  32'(frame_err), 32'h0);
        check("rst_ovr",   32'(overrun), 32'h0);
        reset = 1'b0;
        repeat (5) tick();

        // Single frame, consumer always ready.
        ifc.recvData_ready = 1'b1;
        sendFrame(8'h55, 1'b1, CPB, -1, -1);
        check("single_latency", 32'(firstValid), 32'd155);
        check("single_vcycles", 32'(validCycles), 32'd1);
        check("single_data",    32'(dataFirst), 32'h55);
        check("single_ferr",    32'(ferrCnt), 32'd0);
        check("single_ovr",     32'(ovrCnt), 32'd0);

        // Back-to-back under back-pressure.
        ifc.recvData_ready = 1'b0;
        sendFrame(8'hA3, 1'b1, CPB, -1, -1);
        check("bp_first_latency", 32'(firstValid), 32'd155);
        check("bp_first_data",    32'(dataFirst), 32'hA3);
        sendFrame(8'h0F, 1'b1, CPB, -1, -1);
        check("bp_ovr_count", 32'(ovrCnt), 32'd1);
        check("bp_kept_data", 32'(ifc.recvData), 32'hA3);
        check("bp_valid",     32'(ifc.recvData_valid), 32'h1);
        ifc.recvData_ready = 1'b1;
        tick();
        ifc.recvData_ready = 1'b0;
        check("bp_drained", 32'(ifc.recvData_valid), 32'h0);
        repeat (5) tick();

        // Drain in the exact delivery cycle of the second byte.
        sendFrame(8'hA3, 1'b1, CPB, -1, -1);
        sendFrame(8'h0F, 1'b1, CPB, 155, -1);
        check("coinc_ovr",   32'(ovrCnt), 32'd0);
        check("coinc_data",  32'(ifc.recvData), 32'h0F);
        check("coinc_valid", 32'(ifc.recvData_valid), 32'h1);
        check("coinc_vcont", 32'(validCycles), 32'd160);
        ifc.recvData_ready = 1'b1;
        tick();
        check("coinc_drained", 32'(ifc.recvData_valid), 32'h0);
        repeat (5) tick();

        // Framing error with a long low stop bit, then recovery.
        sendFrame(8'h3C, 1'b0, 2 * CPB, -1, -1);
        check("fe_pulses",  32'(ferrCnt), 32'd1);
        check("fe_valid",   32'(validCycles), 32'd0);
        check("fe_ovr",     32'(ovrCnt), 32'd0);
        check("fe_overlap", 32'(bothCnt), 32'd0);
        repeat (20) tick();
        sendFrame(8'h81, 1'b1, CPB, -1, -1);
        check("fe_next_latency", 32'(firstValid), 32'd155);
        check("fe_next_data",    32'(dataFirst), 32'h81);
        check("fe_next_ferr",    32'(ferrCnt), 32'd0);
        repeat (5) tick();

        // Short glitch on the idle line.
        clearStats();
        rxd = 1'b0;
        repeat (3) tick();
        rxd = 1'b1;
        repeat (40) tick();
        check("glitch_valid", 32'(validCycles), 32'd0);
        check("glitch_ferr",  32'(ferrCnt), 32'd0);
        check("glitch_ovr",   32'(ovrCnt), 32'd0);

        // Reset in the middle of the data bits while a byte is held.
        ifc.recvData_ready = 1'b0;
        sendFrame(8'h5A, 1'b1, CPB, -1, -1);
        check("pre_rst_data", 32'(ifc.recvData), 32'h5A);
        sendFrame(8'hFF, 1'b1, CPB, -1, 64);
        check("midrst_data",  32'(ifc.recvData), 32'h00);
        check("midrst_valid", 32'(ifc.recvData_valid), 32'h0);
        check("midrst_ferr",  32'(ferrCnt), 32'd0);
        check("midrst_ovr",   32'(ovrCnt), 32'd0);
        repeat (5) tick();
        ifc.recvData_ready = 1'b1;
        sendFrame(8'h12, 1'b1, CPB, -1, -1);
        check("post_rst_latency", 32'(firstValid), 32'd155);
        check("post_rst_data",    32'(dataFirst), 32'h12);
        check("post_rst_vcycles", 32'(validCycles), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Synthesizable UART receiver that turns the SoC's serial `rxd` line into bytes on a valid/ready stream. It is the on-chip partner of the simulation-side UART transmit helper: the helper drives `rxd` once per `clk`, and this block recovers 8N1 frames for the LC-3 memory-mapped keyboard/data registers. The block oversamples the line, validates start and stop bits, holds one received byte, and flags framing and overrun errors.

## Interface
- `CLKS_PER_BIT`, default 16: `clk` cycles per bit time; must be an even number ≥ 4.
- `DATA_WIDTH`, default 8: data bits per frame, sent LSB first.

- `clk`  input  1  single clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rxd`  input  1  asynchronous serial line; idles high.
- `recvData`  output  DATA_WIDTH  received byte; stable while `recvData_valid` is high.
- `recvData_valid`  output  1  a byte is held; stays high until accepted.
- `recvData_ready`  input  1  consumer accepts the byte when this is high together with `recvData_valid`.
- `frame_err`  output  1  one-cycle pulse: the stop bit was sampled low.
- `overrun`  output  1  one-cycle pulse: a good frame completed while the holding register was full and not being drained.

## Operation
- Input path: `rxd` passes through a 2-flop synchronizer, then one edge-detect flop. The FSM uses only the synchronized signal `rxs`.
- The FSM has five states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a falling edge on `rxs` clears the baud counter and moves to START.
  - START: after CLKS_PER_BIT/2 − 1 further cycles (the middle of the start bit), sample `rxs`. If 0, clear the counter and bit index and go to DATA. If 1, the edge was a glitch; return to IDLE with no flag.
  - DATA: every CLKS_PER_BIT cycles, sample `rxs` into the shift register at the current bit index (LSB first). After bit DATA_WIDTH−1, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxs`.
    - If 1: deliver the byte (see the holding-register rules) and go to IDLE. This happens at mid stop bit so the next start edge is not missed.
    - If 0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs` == 1, then go to IDLE. This covers break conditions.
- Holding register (one entry). On delivery of a good byte:
  - Register empty: load `recvData` and set `recvData_valid`.
  - Register full and `recvData_ready` low: keep the old byte, drop the new one, pulse `overrun`.
  - Register full and `recvData_ready` high in the same cycle: the old byte is consumed, the new byte is loaded, and `recvData_valid` stays 1. No overrun.
- Acceptance: `recvData_valid && recvData_ready` with no delivery in that cycle clears `recvData_valid` on the next edge.
- Reception runs independently of back-pressure; the receiver never stalls.
- Baud counter width is $clog2(CLKS_PER_BIT). Bit index width is $clog2(DATA_WIDTH+1). Counters reset to 0 on every state entry.

## Timing
- Reset values:
  - `recvData` = 0, `recvData_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - FSM in IDLE; synchronizer and edge flops = 1 (line idle, so no false start after reset).
- Reset mid-frame abandons the frame. There is no flag, and the next falling edge after reset is treated as a new start.
- Latency:
  - Synchronizer: 2 cycles from `rxd` to `rxs`.
  - A start edge at `rxd` cycle T is detected at T+3.
  - The stop sample falls at T+3 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)·CLKS_PER_BIT − 1.
  - `recvData_valid` rises on the edge after the stop sample. For defaults this is T+3+8+144 = T+155.
- `frame_err` and `overrun` are registered and last exactly one cycle. They never assert in the same cycle.
- The byte-to-valid path is registered; no combinational path from `rxd` or `recvData_ready` to any output.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - `UART_DATA_W` = 8;
  - the default `UART_CLKS_PER_BIT` = 16, shared with the future `uart_tx_core`.
- One natural sub-module: `uart_sync`, the 2-flop synchronizer with a parameterized reset value, reused by the TX side for CTS later.
- Core FSM, counters and holding register live in `uart_rx_core`. Target size is about 180 lines.

## Test plan
- **Single frame:** send 0x55 at 16 clks/bit with ready = 1 → `recvData` = 0x55, valid for exactly 1 cycle, 155 cycles after the start edge; no error flags.
- **Back-to-back with back-pressure:** send 0xA3 then 0x0F with ready held low until after the second stop bit.
  - Required: `recvData` = 0xA3 kept, one `overrun` pulse.
  - Then raise ready: 0xA3 accepted and valid drops.
- **Drain coinciding with delivery:** ready pulses in the exact cycle the second byte is delivered → 0xA3 consumed, 0x0F loaded, valid stays 1, no overrun.
- **Framing error:** send 0x3C with the stop bit held low for 2 bit times → one `frame_err` pulse, valid stays 0; a following 0x81 frame is received correctly after the line returns high.
- **Glitch and reset:**
  - A 3-cycle low pulse on idle `rxd` → no byte and no flags.
  - Assert `reset` in the middle of the DATA bits of 0xFF → outputs at reset values; the next frame 0x12 is received correctly.
